mux_tree_pipe: RTL
==================

// Module: mux_tree_pipe
// PURPOSE
//  Parametrised CH:1 multiplexer for DW-bit channels. Built as a log2(CH)-level tree of 2:1 cells.
//  Each tree level is registered, and the stages are linked by a valid/ready handshake.
//  Two select modes: direct (sel port) and auto round-robin scan.
//  Sits between multi-channel sources and a single-lane consumer; successor to the fixed 4:1 tree.
// PARAMETERS
//  CH   4  number of input channels; power of two, >=2
//  DW   8  data width per channel
//  LVL  $clog2(CH)  tree depth = pipeline latency; localparam, not overridable
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       async active-low reset
//  in_data    in   CH*DW   channel c occupies bits [c*DW +: DW]
//  in_valid   in   1       input beat offered
//  in_ready   out  1       input beat accepted when in_valid & in_ready
//  sel        in   LVL     channel select, used when mode=0
//  mode       in   1       0 = direct sel, 1 = round-robin scan
//  out_data   out  DW      selected channel data
//  out_sel    out  LVL     channel index that produced out_data
//  out_valid  out  1       output beat present
//  out_ready  in   1       consumer accepts when out_valid & out_ready
//  scan_ptr   out  LVL     next channel in scan mode
// BEHAVIOUR
//  Reset (async assert, sync release): all stage valids=0, all data/sel regs=0, scan_ptr=0.
//   Hence out_valid=0, out_data=0, out_sel=0 and in_ready=1.
//  Effective select on accept: eff = mode ? scan_ptr : sel.
//   eff is captured with the beat and travels with it.
//  Stage k (k=1..LVL) holds CH>>k lanes.
//   Lane j = eff[k-1] ? lane(2j+1) : lane(2j) of stage k-1.
//   Stage 0 is in_data, so select bits are consumed LSB-first.
//  Handshake: rdy[LVL] = out_ready; rdy[k-1] = ~v[k] | rdy[k]; in_ready = rdy[0].
//   Stage k loads when rdy[k-1]=1; its valid <= v[k-1] (v[0] = in_valid).
//   A stage holds its data/valid unchanged while stalled.
//  Latency: beat accepted at edge t appears with out_valid=1 after edge t+LVL-1, i.e. LVL register stages.
//   Throughput is 1 beat/cycle when out_ready=1.
//  No beat is lost or duplicated. Order is preserved. out_data and out_sel are stable while out_valid & ~out_ready.
//  Scan: scan_ptr increments on each accepted beat while mode=1, wrapping CH-1 -> 0. It holds while mode=0.
//  Mode or sel changes mid-stream affect only beats accepted afterwards. In-flight beats keep their captured select.
//  Simultaneous accept and output pop in a full pipe: all stages advance, in_ready stays 1.
//  Reset mid-operation discards all in-flight beats. Outputs go to reset values immediately.
// STRUCTURE
//  Shared package: log2 helper; MODE_DIRECT=1'b0 and MODE_SCAN=1'b1 constants.
//  Sub-module mux2_stage #(DW, LANES, SW): one registered tree level.
//   Carries lanes, the remaining select bits and the valid bit, with ready in/out.
//  Top module: generate loop over LVL stages, plus the scan_ptr counter.
// TESTING  (CH=4, DW=8, in_data={8'h44,8'h33,8'h22,8'h11} unless stated)
//  1 Reset: rst_n=0 -> out_valid=0, out_data=0, out_sel=0, in_ready=1, scan_ptr=0.
//  2 Direct: mode=0, sel=2, one beat, out_ready=1.
//    -> 2 edges later out_valid=1, out_data=8'h33, out_sel=2.
//  3 Streaming: sel=0,1,2,3 on consecutive cycles.
//    -> out_data 11,22,33,44 on consecutive cycles, no bubbles.
//  4 Backpressure: out_ready=0, 4 beats offered.
//    -> 2 accepted, then in_ready=0, out_data held.
//    -> out_ready=1 drains both in order; the remaining beats are then accepted.
//  5 Scan: mode=1, 6 beats.
//    -> out_sel 0,1,2,3,0,1; out_data 11,22,33,44,11,22; scan_ptr ends at 2.
//  6 Async reset mid-stream with 2 beats in flight.
//    -> out_valid=0 before the next edge, scan_ptr=0, nothing emitted after release.

Source files
------------

// File: rtl/mux_tree_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mux_tree_pipe_pkg
// Purpose : Shared definitions for the pipelined multiplexer tree.
//           - MODE_DIRECT / MODE_SCAN : select-mode encodings for the mode port
//           - log2()                  : ceiling log2 for elaboration-time sizing
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package mux_tree_pipe_pkg;

   localparam logic MODE_DIRECT = 1'b0;   // channel taken from the sel port
   localparam logic MODE_SCAN   = 1'b1;   // channel taken from the scan pointer

   // Ceiling log2, evaluated at elaboration time. Returns 0 for n <= 1.
   function automatic int log2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage : mux_tree_pipe_pkg
`default_nettype wire

// File: rtl/mux_tree_pipe_mux2_stage.sv
`default_nettype none
// ============================================================================
// Module  : mux2_stage
// Purpose : One registered level of the 2:1 multiplexer tree with a
//           valid/ready handshake. Reduces 2*LANES input lanes to LANES
//           output lanes using bit 0 of the travelling select word.
// Ports   : clk      - rising-edge clock
//           rst_n    - asynchronous active-low reset
//           lanes_i  - 2*LANES lanes of DW bits from the previous level
//           sel_i    - travelling select word, next bit to consume at [0]
//           valid_i  - previous level holds a beat
//           ready_o  - this level can load this cycle
//           lanes_o  - LANES registered lanes of DW bits
//           sel_o    - registered select word, rotated for the next level
//           valid_o  - this level holds a beat
//           ready_i  - next level can load this cycle
// Rev     : 1.0  initial release
// ============================================================================
module mux2_stage #(
   parameter int DW    = 8,
   parameter int LANES = 1,
   parameter int SW    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2*LANES*DW-1:0] lanes_i,
   input  logic [SW-1:0]         sel_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [LANES*DW-1:0]   lanes_o,
   output logic [SW-1:0]         sel_o,
   output logic                  valid_o,
   input  logic                  ready_i
);

   logic [LANES*DW-1:0] lanes_d;
   logic [LANES*DW-1:0] lanes_q;
   logic [SW-1:0]       sel_d;
   logic [SW-1:0]       sel_q;
   logic                valid_q;

   // Lane j picks the odd or even input lane of its pair.
   for (genvar j = 0; j < LANES; j++) begin : g_lane
      assign lanes_d[j*DW +: DW] = sel_i[0] ? lanes_i[(2*j+1)*DW +: DW]
                                            : lanes_i[(2*j)*DW +: DW];
   end

   // The full select word travels with the beat so the last level can
   // report the channel index. Rotating right by one each level brings the
   // next unconsumed bit to position 0, and after SW levels the word is back
   // in its original bit order.
   if (SW == 1) begin : g_sel_one
      assign sel_d = sel_i;
   end else begin : g_sel_rot
      assign sel_d = {sel_i[0], sel_i[SW-1:1]};
   end

   // A level may load when empty or when its content moves on this cycle.
   assign ready_o = ~valid_q | ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         lanes_q <= '0;
         sel_q   <= '0;
      end else if (ready_o) begin
         valid_q <= valid_i;
         lanes_q <= lanes_d;
         sel_q   <= sel_d;
      end
   end

   assign lanes_o = lanes_q;
   assign sel_o   = sel_q;
   assign valid_o = valid_q;

endmodule : mux2_stage
`default_nettype wire

// File: rtl/mux_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module  : mux_tree_pipe
// Purpose : Parametrised CH:1 multiplexer for DW-bit channels, built as a
//           log2(CH)-deep tree of registered 2:1 levels linked by valid/ready.
//           Channel select comes from the sel port (direct mode) or from an
//           internal round-robin scan pointer (scan mode). The select is
//           captured with each beat and travels down the tree with it.
// Ports   : clk       - rising-edge clock
//           rst_n     - asynchronous active-low reset
//           in_data   - CH channels, channel c at [c*DW +: DW]
//           in_valid  - input beat offered
//           in_ready  - input beat accepted when in_valid & in_ready
//           sel       - channel select used in direct mode
//           mode      - 0 direct select, 1 round-robin scan
//           out_data  - selected channel data
//           out_sel   - channel index that produced out_data
//           out_valid - output beat present
//           out_ready - consumer accepts when out_valid & out_ready
//           scan_ptr  - channel the next scan-mode beat will use
// Rev     : 1.0  initial release
// ============================================================================
module mux_tree_pipe
   import mux_tree_pipe_pkg::*;
#(
   parameter int CH = 4,
   parameter int DW = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [CH*DW-1:0]       in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [$clog2(CH)-1:0]  sel,
   input  logic                   mode,
   output logic [DW-1:0]          out_data,
   output logic [$clog2(CH)-1:0]  out_sel,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(CH)-1:0]  scan_ptr
);

   localparam int LVL = log2(CH);

   // All tree levels packed into one vector: level k holds CH>>k lanes and
   // starts at lane offset 2*CH - 2*(CH>>k). Level 0 is in_data, level LVL
   // is the single output lane.
   localparam int TREE_LANES = 2 * CH - 1;

   logic [TREE_LANES*DW-1:0] tree;
   logic [LVL-1:0]           sel_lvl [0:LVL];
   logic [LVL:0]             vld;
   logic [LVL:0]             rdy;

   logic [LVL-1:0]           eff_sel;
   logic                     accept;
   logic [LVL-1:0]           scan_ptr_d;
   logic [LVL-1:0]           scan_ptr_q;

   // ------------------------------------------------------------------
   // Tree input and select capture
   // ------------------------------------------------------------------
   assign eff_sel    = (mode == MODE_SCAN) ? scan_ptr_q : sel;
   assign tree[CH*DW-1:0] = in_data;
   assign sel_lvl[0] = eff_sel;
   assign vld[0]     = in_valid;
   assign rdy[LVL]   = out_ready;
   assign in_ready   = rdy[0];
   assign accept     = in_valid & rdy[0];

   // ------------------------------------------------------------------
   // Registered tree levels
   // ------------------------------------------------------------------
   for (genvar k = 1; k <= LVL; k++) begin : g_stage
      localparam int IN_OFS  = 2 * CH - 2 * (CH >> (k - 1));
      localparam int OUT_OFS = 2 * CH - 2 * (CH >> k);
      localparam int LANES   = CH >> k;

      mux2_stage #(
         .DW    (DW),
         .LANES (LANES),
         .SW    (LVL)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .lanes_i (tree[IN_OFS*DW +: 2*LANES*DW]),
         .sel_i   (sel_lvl[k-1]),
         .valid_i (vld[k-1]),
         .ready_o (rdy[k-1]),
         .lanes_o (tree[OUT_OFS*DW +: LANES*DW]),
         .sel_o   (sel_lvl[k]),
         .valid_o (vld[k]),
         .ready_i (rdy[k])
      );
   end

   assign out_data  = tree[(TREE_LANES-1)*DW +: DW];
   assign out_sel   = sel_lvl[LVL];
   assign out_valid = vld[LVL];

   // ------------------------------------------------------------------
   // Round-robin scan pointer: advances only on beats accepted in scan
   // mode; CH is a power of two so the natural wrap is CH-1 -> 0.
   // ------------------------------------------------------------------
   always_comb begin
      scan_ptr_d = scan_ptr_q;
      if (accept && (mode == MODE_SCAN)) begin
         scan_ptr_d = scan_ptr_q + LVL'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_ptr_q <= '0;
      end else begin
         scan_ptr_q <= scan_ptr_d;
      end
   end

   assign scan_ptr = scan_ptr_q;

endmodule : mux_tree_pipe
`default_nettype wire
